// File: rtl/specialist_mem_arbiter_pkg.sv
// Shared types and constants for the Specialist memory-port arbiter.
package specialist_mem_pkg;

  localparam int MEM_AW = 25;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {GR_NONE, GR_LD, GR_CPU, GR_DMA} grant_t;

endpackage

// File: rtl/specialist_mem_arbiter_if.sv
// Byte-wide memory port: the arbiter is master, the SDRAM-backed memory is slave.
interface specialist_mem_arbiter_if
  import specialist_mem_pkg::*;
#(
  parameter int AW = MEM_AW
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [7:0]    mem_dout;
  logic          mem_ready;

  modport master (output mem_addr, mem_din, mem_we, mem_rd, input mem_dout, mem_ready);
  modport slave  (input mem_addr, mem_din, mem_we, mem_rd, output mem_dout, mem_ready);
endinterface

// File: rtl/specialist_mem_arbiter.sv
// Three-port arbiter (loader, CPU, DMA) sequencing one access at a time onto
// the shared byte memory port, with DMA anti-starvation and a WAIT timeout.
module specialist_mem_arbiter
  import specialist_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_busy,
  output logic          ld_ovf,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_wait,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          dma_ack,
  output logic [7:0]    dma_dout,
  output logic          mem_err,
  specialist_mem_arbiter_if.master mem
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, state_nx;
  grant_t        grant, win, grant_now;
  logic          ld_pend;
  logic [AW-1:0] ld_addr_q;
  logic [7:0]    ld_data_q;
  logic          we_q;
  logic [SW-1:0] starve;
  logic [TW-1:0] tmo_cnt;
  logic          cpu_done;
  logic          fin, tmo, ld_done, ld_accept;
  logic [7:0]    rd_val;

  always_comb begin
    win = GR_NONE;
    if (ld_pend)                                   win = GR_LD;
    else if (dma_req && starve == SW'(STARVE_MAX)) win = GR_DMA;
    else if (cpu_req)                              win = GR_CPU;
    else if (dma_req)                              win = GR_DMA;
  end

  assign grant_now = (state == ST_IDLE) ? win : GR_NONE;
  assign fin       = (state == ST_WAIT) && (mem.mem_ready || tmo_cnt == TW'(TIMEOUT));
  assign tmo       = fin && !mem.mem_ready;
  assign rd_val    = mem.mem_ready ? mem.mem_dout : 8'hFF;

  // A loader strobe landing on its own DONE is accepted: pending re-arms.
  assign ld_busy   = ld_pend | (grant == GR_LD);
  assign ld_accept = ld_wr & (~ld_busy | ld_done);
  assign cpu_wait  = cpu_req & ~cpu_done & ~cpu_ack;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (win != GR_NONE) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (fin) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_we = 1'b0;
    mem.mem_rd = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    ld_done    = 1'b0;
    unique case (state)
      ST_ISSUE: begin
        mem.mem_we = we_q;
        mem.mem_rd = ~we_q;
      end
      ST_DONE: begin
        cpu_ack = (grant == GR_CPU);
        dma_ack = (grant == GR_DMA);
        ld_done = (grant == GR_LD);
      end
      default: ;
    endcase
  end

  // Loader latch, grant capture and starvation counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ld_pend      <= 1'b0;
      ld_addr_q    <= '0;
      ld_data_q    <= '0;
      ld_ovf       <= 1'b0;
      grant        <= GR_NONE;
      we_q         <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= '0;
      starve       <= '0;
    end else begin
      if (ld_accept) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end else if (ld_done) begin
        ld_pend <= 1'b0;
      end
      if (ld_wr && !ld_accept) ld_ovf <= 1'b1;

      unique case (grant_now)
        GR_LD: begin
          mem.mem_addr <= ld_addr_q;
          mem.mem_din  <= ld_data_q;
          we_q         <= 1'b1;
        end
        GR_CPU: begin
          mem.mem_addr <= cpu_addr;
          mem.mem_din  <= cpu_din;
          we_q         <= cpu_we;
        end
        GR_DMA: begin
          mem.mem_addr <= dma_addr;
          mem.mem_din  <= dma_din;
          we_q         <= dma_we;
        end
        default: ;
      endcase

      if (grant_now != GR_NONE)  grant <= grant_now;
      else if (state == ST_DONE) grant <= GR_NONE;

      if (!dma_req || grant_now == GR_DMA)
        starve <= '0;
      else if (grant_now == GR_CPU && starve != SW'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end

  // Access completion: timeout counter, read data return, error and wait flags
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_cnt  <= '0;
      mem_err  <= 1'b0;
      cpu_dout <= 8'hFF;
      dma_dout <= 8'hFF;
      cpu_done <= 1'b0;
    end else begin
      if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else                  tmo_cnt <= '0;
      if (tmo) mem_err <= 1'b1;
      if (fin && !we_q) begin
        if (grant == GR_CPU)      cpu_dout <= rd_val;
        else if (grant == GR_DMA) dma_dout <= rd_val;
      end
      if (!cpu_req)     cpu_done <= 1'b0;
      else if (cpu_ack) cpu_done <= 1'b1;
    end
  end

endmodule

// File: doc/specialist_mem_arbiter.md
# specialist_mem_arbiter

Three-port arbiter and sequencer for the single byte-wide SDRAM-backed memory port (`sram`) of the Specialist core. It shares the port between the ioctl loader (ROM/RKS download and erase), the 580VM80A CPU and a DMA requester (disk/tape engines). It replaces the static ioctl/CPU mux at the top level. One access is in flight at a time; each completes on the memory's `ready` pulse, and a timeout guards against a stalled memory.

## Interface
Parameters:
- `AW`, 25, memory address width.
- `STARVE_MAX`, 4, number of consecutive CPU grants while DMA is pending before DMA is forced to win.
- `TIMEOUT`, 63, maximum cycles in WAIT before the access is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk_sys`  in  1  system clock (96 MHz); all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `ld_wr`  in  1  loader write strobe (one cycle).
- `ld_addr`  in  AW  loader address.
- `ld_data`  in  8  loader write data.
- `ld_busy`  out  1  loader write pending or in flight.
- `ld_ovf`  out  1  sticky: `ld_wr` arrived while `ld_busy` was high.
- `cpu_req`  in  1  level; CPU access requested; held until `cpu_ack`.
- `cpu_we`, `cpu_addr[AW]`, `cpu_din[8]`  in  access qualifiers, sampled at grant.
- `cpu_wait`  out  1  high while `cpu_req` is high and the access is not yet acked; drives `pin_ready` low.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_dout`  out  8  read data; held until the next CPU read completes.
- `dma_req`, `dma_we`, `dma_addr[AW]`, `dma_din[8]`  in  same semantics as the CPU port.
- `dma_ack`  out  1  one-cycle completion pulse.
- `dma_dout`  out  8  read data; held.
- `mem_addr`  out  AW  to memory.
- `mem_din`  out  8  to memory.
- `mem_we`, `mem_rd`  out  1  one-cycle command pulses.
- `mem_dout`  in  8  read data, valid with `mem_ready`.
- `mem_ready`  in  1  completion pulse.
- `mem_err`  out  1  sticky: timeout occurred.

## Operation
- Loader latch: `ld_wr` with `ld_busy`=0 captures the address and data and sets pending. `ld_busy` = pending | (grant==LD). `ld_wr` with `ld_busy`=1 is dropped and sets `ld_ovf`.
- Priority, evaluated in IDLE:
  - Loader pending wins.
  - Otherwise, DMA wins if `dma_req` and starve count == `STARVE_MAX`.
  - Otherwise, CPU wins if `cpu_req`.
  - Otherwise, DMA wins if `dma_req`.
- Starve count:
  - Increments on each CPU grant while `dma_req`=1, saturating at `STARVE_MAX`.
  - Clears on DMA grant or when `dma_req`=0.
- FSM states IDLE → ISSUE → WAIT → DONE → IDLE:
  - IDLE: pick a winner; latch its addr/data/we into the mem registers; record the grant.
  - ISSUE: assert `mem_we` (write) or `mem_rd` (read) for exactly one cycle.
  - WAIT: on `mem_ready`, capture `mem_dout` into the granted port's dout (reads only), then go to DONE. If no `mem_ready` after `TIMEOUT` cycles in WAIT, set `mem_err`, deliver dout = 8'hFF for reads, then go to DONE.
  - DONE: pulse the granted port's ack (loader: clear pending), clear the grant, go to IDLE.
- A requester whose req falls before its ack is still completed and acked; the arbiter never cancels a granted access.
- `mem_ready` outside WAIT is ignored.
- Reset values:
  - State IDLE; all acks, `mem_we`, `mem_rd`, `ld_busy`, `ld_ovf`, `mem_err` = 0.
  - Douts = 8'hFF; `mem_addr`/`mem_din` = 0; starve count = 0; pending cleared.
- Reset mid-access abandons the access; a late `mem_ready` after reset is ignored because the state is IDLE.

## Timing
- Request seen in IDLE at cycle 0 → command pulse at cycle 1 → `mem_ready` at cycle 1+N (N≥1) → ack at cycle 2+N → next grant decision at cycle 3+N.
- Minimum throughput is one access per 4 cycles with N=1.
- `cpu_wait` is combinational from `cpu_req` and a registered "cpu_done" flag. The flag sets on `cpu_ack` and clears when `cpu_req` falls.
- `ld_busy` rises the cycle after `ld_wr`. The loader must space strobes ≥ access time; the ioctl rate at 96 MHz satisfies this.
- Simultaneous `ld_wr` and the DONE of a loader access: the new write is accepted, because pending clears and sets in the same cycle with set taking precedence.

## Structure
- Package `specialist_mem_pkg`:
  - `typedef enum {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE}`.
  - `typedef enum {GR_NONE, GR_LD, GR_CPU, GR_DMA}`.
  - Constant `MEM_AW = 25`.
- Single module; no sub-module. The loader latch and starve counter are inline.

## Test plan
- Loader burst: three `ld_wr` strobes (addr 0x100..0x102, data A5/5A/C3) spaced 8 cycles, `mem_ready` 2 cycles after command → three `mem_we` pulses in order with matching addr/data; `ld_ovf`=0.
- CPU read: `cpu_req`=1, `cpu_we`=0, addr 0xC000, `mem_dout`=0x3E, N=3 → `mem_rd` at cycle 1, `cpu_ack` at cycle 5, `cpu_dout`=0x3E; `cpu_wait` high during cycles 0–4 and low once acked.
- Contention: `cpu_req` and `dma_req` held continuously → grant order CPU×4, DMA, CPU×4, DMA.
- Loader priority: `ld_wr` during a CPU WAIT → CPU completes, then the loader is granted before the still-pending CPU and DMA requests.
- Timeout: `mem_ready` never arrives on a DMA read → `dma_ack` 65 cycles after the command, `dma_dout`=0xFF, `mem_err`=1 and sticky.
- Reset mid-WAIT: assert `reset` for 1 cycle, then pulse `mem_ready` → no ack is issued; all outputs are at their reset values; the next `cpu_req` is served normally.
